// File: rtl/led_pattern_pkg.sv
// Shared types and constants for the LED pattern sequencer (led_pattern_ctrl).
package led_pattern_pkg;

  localparam int unsigned CNT_W = 25;
  localparam int unsigned LED_W = 8;
  localparam int unsigned DB_W  = 18;

  typedef enum logic [1:0] {
    ModeShiftL = 2'b00,
    ModeShiftR = 2'b01,
    ModeBounce = 2'b10,
    ModeBlink  = 2'b11
  } mode_e;

  typedef enum logic {
    StRun   = 1'b0,
    StPause = 1'b1
  } run_state_e;

  typedef enum logic {
    DirLeft  = 1'b0,
    DirRight = 1'b1
  } dir_e;

  localparam logic [LED_W-1:0] SEED_SHIFT = 8'h01;
  localparam logic [LED_W-1:0] SEED_BLINK = 8'hFF;

  function automatic logic [LED_W-1:0] mode_seed(input mode_e mode);
    return (mode == ModeBlink) ? SEED_BLINK : SEED_SHIFT;
  endfunction

endpackage

// File: rtl/step_timer.sv
// Step timebase: period counter with pause hold, one-cycle tick, and a period
// register that only reloads on a tick so the step in progress is never cut short.
module step_timer
  import led_pattern_pkg::*;
#(
  parameter int unsigned P_FAST = 6250000,
  parameter int unsigned P_MID  = 12500000,
  parameter int unsigned P_SLOW = 25000000
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       run,
  input  logic [1:0] speed,
  output logic       tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] period_sel;

  always_comb begin
    case (speed)
      2'b00:   period_sel = CNT_W'(P_FAST);
      2'b11:   period_sel = CNT_W'(P_SLOW);
      default: period_sel = CNT_W'(P_MID);
    endcase
  end

  assign tick = run && (cnt_q == (period_q - 1'b1));

  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    if (tick) begin
      cnt_d    = '0;
      period_d = period_sel;
    end else if (run) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt_q    <= '0;
      period_q <= CNT_W'(P_MID);
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
    end
  end

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED pattern sequencer: input sync, run/pause FSM and pattern FSM on a step tick.
// Define SW_DEBOUNCE_EN to add per-input stability counters after the synchronisers.
module led_pattern_ctrl
  import led_pattern_pkg::*;
#(
  parameter int unsigned P_FAST       = 6250000,
  parameter int unsigned P_MID        = 12500000,
  parameter int unsigned P_SLOW       = 25000000,
  parameter int unsigned DEBOUNCE_CYC = 240000
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [3:0]       sw,
  input  logic             key_n,
  output logic [LED_W-1:0] led,
  output logic             tick_out,
  output logic             paused
);

  logic [3:0] sw_meta_q, sw_s_q;
  logic       key_meta_q, key_s_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sw_meta_q  <= '1;
      sw_s_q     <= '1;
      key_meta_q <= 1'b1;
      key_s_q    <= 1'b1;
    end else begin
      sw_meta_q  <= sw;
      sw_s_q     <= sw_meta_q;
      key_meta_q <= key_n;
      key_s_q    <= key_meta_q;
    end
  end

  logic [3:0] sw_c;
  logic       key_c;

`ifdef SW_DEBOUNCE_EN
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

  logic [3:0]      sw_cand_q, sw_db_q;
  logic [DB_W-1:0] sw_stab_q;
  logic            key_cand_q, key_db_q;
  logic [DB_W-1:0] key_stab_q;

  // A new value restarts the count at 1 so it is accepted after DEBOUNCE_CYC stable cycles.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sw_cand_q <= '1;
      sw_db_q   <= '1;
      sw_stab_q <= '0;
    end else if (sw_s_q != sw_cand_q) begin
      sw_cand_q <= sw_s_q;
      sw_stab_q <= DB_W'(1);
    end else if (sw_stab_q >= DB_LAST) begin
      sw_db_q <= sw_cand_q;
    end else begin
      sw_stab_q <= sw_stab_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      key_cand_q <= 1'b1;
      key_db_q   <= 1'b1;
      key_stab_q <= '0;
    end else if (key_s_q != key_cand_q) begin
      key_cand_q <= key_s_q;
      key_stab_q <= DB_W'(1);
    end else if (key_stab_q >= DB_LAST) begin
      key_db_q <= key_cand_q;
    end else begin
      key_stab_q <= key_stab_q + 1'b1;
    end
  end

  assign sw_c  = sw_db_q;
  assign key_c = key_db_q;
`else
  assign sw_c  = sw_s_q;
  assign key_c = key_s_q;
`endif

  logic key_prev_q;
  logic key_press;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      key_prev_q <= 1'b1;
    end else begin
      key_prev_q <= key_c;
    end
  end

  assign key_press = key_prev_q & ~key_c;

  run_state_e state_q, state_d;
  logic       run;
  logic       tick;

  always_comb begin
    state_d = state_q;
    if (key_press) begin
      state_d = (state_q == StRun) ? StPause : StRun;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  assign run = (state_q == StRun);

  step_timer #(
    .P_FAST (P_FAST),
    .P_MID  (P_MID),
    .P_SLOW (P_SLOW)
  ) u_step_timer (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .run      (run),
    .speed    (sw_c[1:0]),
    .tick     (tick)
  );

  mode_e            mode_q, mode_d, mode_sw;
  dir_e             dir_q, dir_d;
  logic [LED_W-1:0] led_q, led_d;

  assign mode_sw = mode_e'(sw_c[3:2]);

  always_comb begin
    led_d  = led_q;
    mode_d = mode_q;
    dir_d  = dir_q;
    if (tick) begin
      mode_d = mode_sw;
      if (mode_sw != mode_q) begin
        led_d = mode_seed(mode_sw);
        dir_d = DirLeft;
      end else begin
        case (mode_q)
          ModeShiftL: led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
          ModeShiftR: led_d = {led_q[0], led_q[LED_W-1:1]};
          ModeBounce: begin
            // Turn around as the end bit is entered so it is shown for a single tick.
            if (dir_q == DirLeft) begin
              if (led_q[LED_W-1]) begin
                led_d = led_q >> 1;
                dir_d = DirRight;
              end else begin
                led_d = led_q << 1;
                if (led_q[LED_W-2]) dir_d = DirRight;
              end
            end else begin
              if (led_q[0]) begin
                led_d = led_q << 1;
                dir_d = DirLeft;
              end else begin
                led_d = led_q >> 1;
                if (led_q[1]) dir_d = DirLeft;
              end
            end
          end
          ModeBlink: led_d = ~led_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      led_q  <= SEED_SHIFT;
      mode_q <= ModeShiftL;
      dir_q  <= DirLeft;
    end else begin
      led_q  <= led_d;
      mode_q <= mode_d;
      dir_q  <= dir_d;
    end
  end

  assign led      = led_q;
  assign tick_out = tick;
  assign paused   = (state_q == StPause);

endmodule

// File: doc/led_pattern_ctrl.md
# led_pattern_ctrl

Programmable LED pattern sequencer for the STEP-MAX10 demo. It synchronises the board switches and selects a step period from them. It generates a one-cycle step tick from the 12 MHz clock and steps an 8-bit LED pattern state machine on each tick. A push key toggles run/pause. The block sits between the board I/O (switches, key, LEDs) and replaces the free-running divider output as the demo's visible timebase.

## Interface
- P_FAST, 6250000: step period in clk_in cycles when sw[1:0]=00.
- P_MID, 12500000: step period when sw[1:0]=01 or 10.
- P_SLOW, 25000000: step period when sw[1:0]=11.
- DEBOUNCE_CYC, 240000: stable-cycles requirement (20 ms at 12 MHz); used only with SW_DEBOUNCE_EN.

- clk_in, input, 1: 12 MHz system clock; single clock domain.
- rst_n_in, input, 1: reset, asynchronous, active-low.
- sw, input, 4: board switches, asynchronous; [1:0] speed, [3:2] mode.
- key_n, input, 1: push key, asynchronous, active-low; each press toggles run/pause.
- led, output, 8: LED pattern, active-high.
- tick_out, output, 1: one-cycle pulse per pattern step.
- paused, output, 1: high while in PAUSE.

## Operation
- Input conditioning: sw and key_n each pass through a 2-flop synchroniser, giving sw_s and key_s. A key press is a 1→0 transition of key_s, detected against a registered copy.
- Run FSM has two states, RUN and PAUSE. Reset enters RUN.
  - A key press toggles RUN↔PAUSE.
  - In PAUSE the period counter holds its value, tick_out=0, and led holds.
  - On PAUSE→RUN, counting resumes from the held value.
- Period counter: 25-bit cnt counts 0..period_q-1.
  - When cnt==period_q-1 in RUN: tick_out=1 for one cycle and cnt wraps to 0.
  - period_q is reloaded from the speed decode of the conditioned sw[1:0] only on a tick cycle. A speed change therefore never truncates or extends the step in progress.
- Pattern FSM modes, taken from the conditioned sw[3:2]:
  - 00 SHIFT_L: rotate led left.
  - 01 SHIFT_R: rotate led right.
  - 10 BOUNCE: single lit bit moves by one position per tick; direction reverses at bit 7 and bit 0. The end bit is shown for exactly one tick.
  - 11 BLINK: led alternates 8'h00 and 8'hFF.
- Mode register mode_q is sampled on tick cycles only.
  - If the sampled mode differs from mode_q, led loads that mode's seed instead of stepping, and BOUNCE direction resets to left.
  - Seeds: SHIFT_L, SHIFT_R and BOUNCE use 8'h01; BLINK uses 8'hFF.
- Simultaneous key press and tick in the same cycle: the tick completes (led steps, period_q/mode_q update) and the state becomes PAUSE from the next cycle.
- Reset values:
  - Outputs: led=8'h01, tick_out=0, paused=0.
  - Internal state: cnt=0, period_q=P_MID, mode_q=SHIFT_L, direction=left, synchronisers all-ones.

## Timing
- The sw/key synchroniser adds 2 cycles of latency. Press detection lands on the 3rd clk_in edge after the key_n fall.
- led updates on the clock edge that ends the tick_out cycle, i.e. led changes together with tick_out falling.
- Step period is exactly period_q cycles, tick to tick, in RUN.
- Reset asserted mid-operation returns all state to reset values immediately (asynchronous). The first tick after release occurs P_MID cycles later.
- Legal parameter range: 2 ≤ period < 2^25.

## Configuration
- SW_DEBOUNCE_EN defined:
  - The conditioned sw is accepted only after sw_s has been stable for DEBOUNCE_CYC consecutive cycles.
  - key_s is debounced the same way before edge detection.
  - Each input has its own 18-bit stability counter.
- SW_DEBOUNCE_EN undefined: the synchroniser outputs are used directly and no stability counters are built.

## Structure
- Package led_pattern_pkg holds:
  - mode enum (SHIFT_L, SHIFT_R, BOUNCE, BLINK)
  - run-state enum (RUN, PAUSE)
  - seed constants
  - counter width constant CNT_W=25
- Sub-module step_timer: period counter, period_q reload, tick generation, pause hold.
- Top level: synchronisers, optional debounce, key edge detection, run FSM, pattern FSM.

## Test plan
Bench overrides P_FAST=8, P_MID=16, P_SLOW=32, DEBOUNCE_CYC=4.
- Reset, then sw=0000 → led=01 until the first tick 16 cycles after release. After that tick, led=02 and period becomes 8; further ticks every 8 cycles, led 04, 08, …, 80, then 01.
- sw[3:2]=10 → mode loads seed 01 on the next tick; led then runs 01, 02, …, 80, 40, …, 01, with each end bit held one tick.
- Change sw[1:0] from 11 to 00 mid-step → the current step still lasts 32 cycles; later steps last 8 cycles.
- key_n pulse low in RUN → paused=1 and tick_out stays 0 for 100 cycles with led frozen. A second press resumes; the next tick arrives after the remaining count.
- Key press coincident with a tick → led steps once, then paused=1.
- Debounce build: toggle sw[3:2] for fewer than 4 cycles → mode unchanged. Hold it ≥4 cycles → new mode seed loads on the next tick.
- rst_n_in pulsed low mid-BOUNCE → led=01, paused=0 immediately.
